// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    MEM_READ  = 2'd2,
    MEM_WRITE = 2'd3
  } cache_state_t;

  localparam int ADDRESS_WIDTH_DEFAULT = 8;
  localparam int DATA_WIDTH_DEFAULT    = 32;

  // Byte address = tag | index | 2-bit byte offset; one word per line.
  function automatic int tag_width(input int address_width, input int data_width);
    return data_width - address_width - 2;
  endfunction

  localparam int INDEX_WIDTH_DEFAULT = ADDRESS_WIDTH_DEFAULT;
  localparam int TAG_WIDTH_DEFAULT   = tag_width(ADDRESS_WIDTH_DEFAULT, DATA_WIDTH_DEFAULT);

endpackage

// File: rtl/cache_tag_store.sv
// Tag array and valid vector: combinational lookup, one write port, one-cycle flush.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int INDEX_W = INDEX_WIDTH_DEFAULT,
  parameter int TAG_W   = TAG_WIDTH_DEFAULT
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iFlush,
  input  logic [INDEX_W-1:0] iLookupIndex,
  output logic [TAG_W-1:0]   oLookupTag,
  output logic               oLookupValid,
  input  logic               iWriteEn,
  input  logic [INDEX_W-1:0] iWriteIndex,
  input  logic [TAG_W-1:0]   iWriteTag
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  // Flush has priority; the controller never asks for both in one cycle anyway.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      valid_q <= '0;
    end else if (iFlush) begin
      valid_q <= '0;
    end else if (iWriteEn) begin
      valid_q[iWriteIndex] <= 1'b1;
    end
  end

  // Tags need no reset: a line is only trusted when its valid bit is set.
  always_ff @(posedge iCLK) begin
    if (iWriteEn) begin
      tag_q[iWriteIndex] <= iWriteTag;
    end
  end

  assign oLookupTag   = tag_q[iLookupIndex];
  assign oLookupValid = valid_q[iLookupIndex];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache sequencer with hit/miss counters.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT
) (
  input  logic                     iCLK,
  input  logic                     iRSTn,
  input  logic                     iReq,
  input  logic                     iWrite,
  input  logic [DATA_WIDTH-1:0]    iAddress,
  input  logic [DATA_WIDTH-1:0]    iWData,
  input  logic                     iFlush,
  output logic                     oReady,
  output logic                     oValid,
  output logic [DATA_WIDTH-1:0]    oRData,
  output logic                     oHit,
  output logic [31:0]              oHitCount,
  output logic [31:0]              oMissCount,
  output logic                     oCacheWE,
  output logic [ADDRESS_WIDTH-1:0] oCacheIndex,
  output logic [DATA_WIDTH-1:0]    oCacheWData,
  input  logic [DATA_WIDTH-1:0]    iCacheRData,
  output logic                     oMemReq,
  output logic                     oMemWrite,
  output logic [DATA_WIDTH-1:0]    oMemAddress,
  output logic [DATA_WIDTH-1:0]    oMemWData,
  input  logic                     iMemAck,
  input  logic [DATA_WIDTH-1:0]    iMemRData,
  output cache_state_t             oState
);

  localparam int TAG_W  = tag_width(ADDRESS_WIDTH, DATA_WIDTH);
  localparam int WORD_W = DATA_WIDTH - 2;

  // Handshakes: the CPU request transfers on a cycle with iReq && oReady; oValid is a
  // single-cycle completion pulse with no back-pressure. The memory side holds oMemReq and
  // all its qualifiers stable until the cycle iMemAck is seen high while oMemReq is high.

  cache_state_t             state_q, state_d;
  logic [WORD_W-1:0]        word_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [31:0]              hit_count_q, miss_count_q;

  logic [ADDRESS_WIDTH-1:0] index_q, req_index;
  logic [TAG_W-1:0]         req_tag_q, lookup_tag;
  logic                     lookup_valid;
  logic                     in_idle, in_lookup, in_read, in_write, mem_busy;
  logic                     accept, flush_now, hit, fill;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^iAddress[1:0];

  assign in_idle   = (state_q == IDLE);
  assign in_lookup = (state_q == LOOKUP);
  assign in_read   = (state_q == MEM_READ);
  assign in_write  = (state_q == MEM_WRITE);
  assign mem_busy  = in_read || in_write;

  assign index_q   = word_q[ADDRESS_WIDTH-1:0];
  assign req_tag_q = word_q[WORD_W-1:ADDRESS_WIDTH];
  assign req_index = iAddress[ADDRESS_WIDTH+1:2];

  assign flush_now = in_idle && iFlush;
  assign oReady    = in_idle && !iFlush;
  assign accept    = iReq && oReady;
  assign hit       = in_lookup && lookup_valid && (lookup_tag == req_tag_q);
  assign fill      = in_read && iMemAck;

  cache_tag_store #(
    .INDEX_W (ADDRESS_WIDTH),
    .TAG_W   (TAG_W)
  ) u_tag_store (
    .iCLK         (iCLK),
    .iRSTn        (iRSTn),
    .iFlush       (flush_now),
    .iLookupIndex (index_q),
    .oLookupTag   (lookup_tag),
    .oLookupValid (lookup_valid),
    .iWriteEn     (fill),
    .iWriteIndex  (index_q),
    .iWriteTag    (req_tag_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = LOOKUP;
      LOOKUP: begin
        if (write_q)  state_d = MEM_WRITE;
        else if (hit) state_d = IDLE;
        else          state_d = MEM_READ;
      end
      MEM_READ:  if (iMemAck) state_d = IDLE;
      MEM_WRITE: if (iMemAck) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q      <= IDLE;
      word_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q  <= iAddress[DATA_WIDTH-1:2];
        write_q <= iWrite;
        wdata_q <= iWData;
      end
      // Counters wrap naturally at 32 bits.
      if (in_lookup) begin
        if (hit) hit_count_q  <= hit_count_q + 32'd1;
        else     miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign oHit       = hit;
  assign oValid     = (hit && !write_q) || (mem_busy && iMemAck);
  assign oRData     = (hit && !write_q) ? iCacheRData :
                      fill              ? iMemRData   : '0;
  assign oHitCount  = hit_count_q;
  assign oMissCount = miss_count_q;
  assign oState     = state_q;

  // Store hits update the array in LOOKUP; refills write it in the ack cycle.
  assign oCacheWE    = (hit && write_q) || fill;
  assign oCacheIndex = in_idle ? req_index : index_q;
  assign oCacheWData = in_read ? iMemRData : wdata_q;

  assign oMemReq     = mem_busy;
  assign oMemWrite   = in_write;
  assign oMemAddress = mem_busy ? {word_q, 2'b00} : '0;
  assign oMemWData   = in_write ? wdata_q : '0;

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM for the direct-mapped data cache between the CPU load/store unit and main memory. Owns the tag and valid store, decides hit/miss for each request and drives the cache data array's write port. On a read miss it refills from memory, and every write goes through to memory. Reports hit/miss events and running counters for performance tracking.

## Interface
Parameters:
- ADDRESS_WIDTH, 8, log2 of line count; one 32-bit word per line
- DATA_WIDTH, 32, word and address width

Ports (one clock; reset is asynchronous and active-low):
- iCLK  in  1  clock, all state updates on rising edge
- iRSTn  in  1  asynchronous active-low reset
- iReq  in  1  CPU request valid
- iWrite  in  1  1 = store, 0 = load; sampled with iReq
- iAddress  in  DATA_WIDTH  byte address; bits [1:0] ignored
- iWData  in  DATA_WIDTH  store data
- iFlush  in  1  invalidate all lines
- oReady  out  1  controller can accept iReq this cycle
- oValid  out  1  one-cycle pulse: request complete
- oRData  out  DATA_WIDTH  load data, valid when oValid && load
- oHit  out  1  one-cycle pulse in LOOKUP on tag match
- oHitCount, oMissCount  out  32 each  event counters
- oCacheWE  out  1  data-array write enable
- oCacheIndex  out  ADDRESS_WIDTH  data-array index
- oCacheWData  out  DATA_WIDTH  data-array write data
- iCacheRData  in  DATA_WIDTH  data-array combinational read data at oCacheIndex
- oMemReq  out  1  memory request
- oMemWrite  out  1  memory request is a write
- oMemAddress  out  DATA_WIDTH  word-aligned memory address
- oMemWData  out  DATA_WIDTH  memory write data
- iMemAck  in  1  memory completion; read data on iMemRData this cycle
- iMemRData  in  DATA_WIDTH  memory read data

## Operation
- Address split: index = iAddress[ADDRESS_WIDTH+1:2]; tag = iAddress[DATA_WIDTH-1:ADDRESS_WIDTH+2].
- States: IDLE, LOOKUP, MEM_READ, MEM_WRITE.
- IDLE:
  - oReady = 1 unless iFlush is high.
  - iReq && oReady latches address, data and iWrite, then moves to LOOKUP.
  - iFlush clears all valid bits that cycle. Flush wins over a simultaneous iReq, which is not accepted.
  - iFlush outside IDLE is ignored.
- LOOKUP: hit = valid[index] && tag match. oHit = hit.
  - Load hit: oValid = 1, oRData = iCacheRData, oHitCount++, go to IDLE.
  - Load miss: oMissCount++, go to MEM_READ.
  - Store hit: oCacheWE = 1 with iWData, oHitCount++, go to MEM_WRITE.
  - Store miss: oMissCount++, go to MEM_WRITE. No allocate, no array write.
- MEM_READ: oMemReq = 1, oMemWrite = 0. On iMemAck:
  - oCacheWE = 1 with iMemRData.
  - tag[index] and valid[index] are written.
  - oValid = 1, oRData = iMemRData, go to IDLE.
- MEM_WRITE: oMemReq = oMemWrite = 1, oMemWData = latched data. On iMemAck: oValid = 1, go to IDLE.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Reset values:
  - state IDLE, all valid bits 0, counters 0.
  - oValid, oHit, oCacheWE, oMemReq, oMemWrite = 0; oRData, oMemAddress, oMemWData = 0.
  - oReady = 1 once out of reset.

## Timing
- Load hit: accepted at edge N; oValid at cycle N+1; oReady high again in cycle N+2. Latency 2 cycles.
- Load miss: oMemReq asserted from cycle N+2 until the ack cycle inclusive. oValid in the ack cycle.
- Memory handshake:
  - oMemReq, oMemAddress, oMemWrite and oMemWData stay stable until iMemAck.
  - The earliest acceptable ack is the first cycle oMemReq is high.
  - iMemAck while oMemReq is low is ignored.
- oCacheIndex = latched index outside IDLE, iAddress index in IDLE.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). An outstanding memory request is abandoned.
- Back-to-back requests: iReq may be held high. The next request is accepted in the cycle after oValid.

## Structure
- Package cache_pkg holds:
  - state enum cache_state_t {IDLE, LOOKUP, MEM_READ, MEM_WRITE}
  - localparams for index/tag widths derived from ADDRESS_WIDTH and DATA_WIDTH
- Sub-module cache_tag_store holds the tag array and valid vector:
  - async-reset valid bits
  - single-cycle flush
  - combinational lookup port, one write port

## Test plan
- Cold load 0x0000_0010 with memory returning 0xDEADBEEF after 3 cycles:
  - oMemReq for 3 cycles, oValid with oRData = 0xDEADBEEF
  - oMissCount = 1
- Repeat load of 0x0000_0010: oHit pulses, oValid on cycle 2, oRData = 0xDEADBEEF, no oMemReq, oHitCount = 1.
- Conflicting address 0x0000_0410 (same index, ADDRESS_WIDTH = 8): treated as a miss and refilled. A following load of 0x10 misses again.
- Store 0x12345678 to 0x10 after a fill: array written that cycle, memory write issued. A later load returns 0x12345678 as a hit.
- Store to uncached 0x20: memory write only, oCacheWE stays 0. A later load of 0x20 misses.
- Flush asserted with iReq in IDLE: oReady = 0 and the request is not accepted. A subsequent load of 0x10 misses.
- Reset pulsed during MEM_READ: oMemReq drops asynchronously, counters read 0.
